// File: rtl/conv_icb_sram_pkg.sv
// conv_icb_sram_pkg: ICB widths, SRAM window defaults and the response entry type
package conv_icb_sram_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 32'h1005_0000;
    localparam int SRAM_AW_DEF = 12;
    localparam int RSP_DEPTH_DEF = 3;
    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;
endpackage

// File: rtl/conv_icb_rsp_fifo.sv
// conv_icb_rsp_fifo: in-order response queue with occupancy count
module conv_icb_rsp_fifo
    import conv_icb_sram_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  rsp_t                         din,
    input  logic                         pop,
    output rsp_t                         dout,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    rsp_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH-1) ? '0 : p + PW'(1);
    endfunction
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    assign valid = count != '0;
    // An empty queue presents zeros so the response outputs are clean after reset
    assign dout  = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/conv_icb_sram.sv
// conv_icb_sram: ICB slave bridging the conv core to a single-port SRAM, responses in order
module conv_icb_sram
    import conv_icb_sram_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int                SRAM_AW   = SRAM_AW_DEF,
    parameter int                RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               conv_icb_cmd_valid,
    output logic               conv_icb_cmd_ready,
    input  logic [ADDR_W-1:0]  conv_icb_cmd_addr,
    input  logic               conv_icb_cmd_read,
    input  logic [DATA_W-1:0]  conv_icb_cmd_wdata,
    input  logic [MASK_W-1:0]  conv_icb_cmd_wmask,
    output logic               conv_icb_rsp_valid,
    input  logic               conv_icb_rsp_ready,
    output logic [DATA_W-1:0]  conv_icb_rsp_rdata,
    output logic               conv_icb_rsp_err,
    output logic               sram_cs,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    output logic [MASK_W-1:0]  sram_wem,
    input  logic [DATA_W-1:0]  sram_rdata
);
    localparam int CW = $clog2(RSP_DEPTH+1);
    logic          fire, hit, err, pop;
    logic          pend_vld, pend_read, pend_err;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    rsp_t          push_ent, head;
    // Pending stage reserves a FIFO slot, so ready only looks at registered occupancy
    assign occ                = {1'b0, count} + (CW+1)'(pend_vld);
    assign conv_icb_cmd_ready = !rst && occ < (CW+1)'(RSP_DEPTH);
    assign fire               = conv_icb_cmd_valid && conv_icb_cmd_ready;
    assign hit = conv_icb_cmd_addr[ADDR_W-1:SRAM_AW+2] == BASE_ADDR[ADDR_W-1:SRAM_AW+2];
    assign err = !hit || conv_icb_cmd_addr[1:0] != 2'b00;
    assign sram_cs    = fire && !err;
    assign sram_we    = !conv_icb_cmd_read;
    assign sram_addr  = conv_icb_cmd_addr[SRAM_AW+1:2];
    assign sram_wdata = conv_icb_cmd_wdata;
    assign sram_wem   = conv_icb_cmd_read ? '0 : conv_icb_cmd_wmask;
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_read <= 1'b0;
            pend_err  <= 1'b0;
        end else begin
            pend_vld  <= fire;
            pend_read <= conv_icb_cmd_read;
            pend_err  <= err;
        end
    end
    assign push_ent.rdata = (pend_read && !pend_err) ? sram_rdata : {DATA_W{1'b0}};
    assign push_ent.err   = pend_err;
    assign pop            = conv_icb_rsp_valid && conv_icb_rsp_ready;
    conv_icb_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pend_vld),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .valid (conv_icb_rsp_valid),
        .count (count)
    );
    assign conv_icb_rsp_rdata = head.rdata;
    assign conv_icb_rsp_err   = head.err;
endmodule

// File: tb/tb_conv_icb_sram.sv
// tb_conv_icb_sram: random and directed traffic against a transaction-level memory model
module tb_conv_icb_sram;
    localparam logic [31:0] BASE = 32'h1005_0000;
    localparam logic [31:0] WIN  = 32'h0000_4000;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_read = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;
    logic        sram_cs, sram_we;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [3:0]  sram_wem;
    conv_icb_sram dut (
        .clk                (clk),
        .rst                (rst),
        .conv_icb_cmd_valid (cmd_valid),
        .conv_icb_cmd_ready (cmd_ready),
        .conv_icb_cmd_addr  (cmd_addr),
        .conv_icb_cmd_read  (cmd_read),
        .conv_icb_cmd_wdata (cmd_wdata),
        .conv_icb_cmd_wmask (cmd_wmask),
        .conv_icb_rsp_valid (rsp_valid),
        .conv_icb_rsp_ready (rsp_ready),
        .conv_icb_rsp_rdata (rsp_rdata),
        .conv_icb_rsp_err   (rsp_err),
        .sram_cs            (sram_cs),
        .sram_we            (sram_we),
        .sram_addr          (sram_addr),
        .sram_wdata         (sram_wdata),
        .sram_wem           (sram_wem),
        .sram_rdata         (sram_rdata)
    );
    initial forever #5 clk = ~clk;
    // External SRAM: byte-masked write, registered read
    logic [31:0] sram_mem [4096];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int i = 0; i < 4; i++)
                    if (sram_wem[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
            end else sram_rdata <= sram_mem[sram_addr];
        end
    end
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [4096];
    int          n_chk = 0, n_pass = 0, cyc = 0, fire_cnt = 0, rsp_cnt = 0;
    logic        fired = 1'b0, strict = 1'b0, last_err = 1'b0;
    logic [31:0] last_rdata = '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask
    function automatic logic in_win(input logic [31:0] a);
        return a >= BASE && a < BASE + WIN;
    endfunction
    // Observe one cycle in the low phase, update the model, then advance to the next negedge
    task automatic step();
        #1;
        fired = cmd_valid && cmd_ready;
        if (fired) begin
            logic        e;
            logic [11:0] w;
            logic [31:0] d;
            e = !in_win(cmd_addr) || cmd_addr[1:0] != 2'b00;
            w = 12'((cmd_addr - BASE) >> 2);
            d = '0;
            check("sram_cs", sram_cs, !e);
            if (!e) begin
                check("sram_addr", sram_addr, w);
                check("sram_we", sram_we, !cmd_read);
                check("sram_wem", sram_wem, cmd_read ? 4'h0 : cmd_wmask);
                if (cmd_read) d = ref_mem[w];
                else begin
                    check("sram_wdata", sram_wdata, cmd_wdata);
                    for (int b = 0; b < 4; b++)
                        if (cmd_wmask[b]) ref_mem[w][8*b +: 8] = cmd_wdata[8*b +: 8];
                end
            end
            exp_q.push_back('{d, e, cyc});
            fire_cnt++;
        end else check("sram_cs_idle", sram_cs, 0);
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("stray_rsp", rsp_valid, 0);
            else begin
                exp_t x = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, x.rdata);
                check("rsp_err", rsp_err, x.err);
                if (strict) check("latency", cyc - x.cyc, 2);
                else check("latency_min", cyc - x.cyc >= 2, 1);
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                rsp_cnt++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask
    task automatic send(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        cmd_valid = 1'b1;
        cmd_read  = r;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wmask = m;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fired) break;
        end
        if (!fired) check("send_timeout", fired, 1);
        cmd_valid = 1'b0;
    endtask
    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        check("drain_empty", exp_q.size(), 0);
        repeat (3) step();
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_sram_cs", sram_cs, 0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        send(1'b0, BASE + 32'h10, 32'hA5A5_1234, 4'hF);
        send(1'b1, BASE + 32'h10, 32'h0, 4'h0);
        drain();
        check("wr_rd_data", last_rdata, 32'hA5A5_1234);
        send(1'b0, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
        send(1'b0, BASE + 32'h20, 32'h0000_0000, 4'b0101);
        send(1'b1, BASE + 32'h20, 32'h0, 4'h0);
        drain();
        check("partial_mask", last_rdata, 32'hFF00_FF00);
        send(1'b1, 32'h1004_0000, 32'h0, 4'h0);
        send(1'b1, 32'h1005_0002, 32'h0, 4'h0);
        drain();
        check("err_last", last_err, 1);
        check("err_rdata", last_rdata, 0);
        for (int w = 0; w < 16; w++) send(1'b0, BASE + 32'(4 * w), $urandom, 4'hF);
        drain();
        strict = 1'b1;
        fire_cnt = 0;
        rsp_cnt = 0;
        cmd_valid = 1'b1;
        cmd_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cmd_addr = BASE + 32'(4 * i);
            step();
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", fire_cnt, 16);
        drain();
        check("b2b_rsps", rsp_cnt, 16);
        strict = 1'b0;
        rsp_ready = 1'b0;
        fire_cnt = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd_addr = BASE + 32'(4 * $urandom_range(0, 15));
            step();
        end
        cmd_valid = 1'b0;
        check("bp_accepts", fire_cnt, 3);
        check("bp_ready_low", cmd_ready, 0);
        drain();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, BASE + 32'(4 * i), 32'h0, 4'h0);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        #1;
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_cmd_ready", cmd_ready, 1);
        rsp_ready = 1'b1;
        repeat (4) step();
        send(1'b0, BASE + 32'h30, 32'h1234_5678, 4'hF);
        send(1'b1, BASE + 32'h30, 32'h0, 4'h0);
        drain();
        check("post_rst_data", last_rdata, 32'h1234_5678);
        for (int i = 0; i < 400; i++) begin
            int k;
            k = int'($urandom_range(0, 9));
            cmd_valid = $urandom_range(0, 9) < 7;
            rsp_ready = $urandom_range(0, 9) < 7;
            cmd_read  = 1'($urandom_range(0, 1));
            cmd_wdata = $urandom;
            cmd_wmask = 4'($urandom_range(0, 15));
            cmd_addr  = k < 8  ? BASE + 32'(4 * $urandom_range(0, 15)) :
                        k == 8 ? ($urandom_range(0, 1) != 0 ? BASE + WIN + 32'(4 * $urandom_range(0, 7)) : BASE - 32'd4) :
                                 BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            step();
        end
        cmd_valid = 1'b0;
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
